// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - per-neuron bias+partial-sum accumulator with shift, saturation and valid/ready output
// Optional ReLU before saturation: define NEURON_ACC_RELU_EN.
module neuron_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [16:0] in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [15:0]       out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [ACC_W-1:0]  bias_ext, sum_ext, acc_next, shifted, clamped;
    logic signed [15:0]       sat_data;
    logic                     sat_flag;
    logic                     accept, last_term;

    assign bias_ext = {{(ACC_W-16){bias[15]}}, bias};
    assign sum_ext  = {{(ACC_W-17){in_sum[16]}}, in_sum};

    // The bias enters only with the first term, so its value in later cycles is irrelevant.
    always_comb begin
        acc_next = ((cnt_q == '0) ? bias_ext : acc_q) + sum_ext;
        shifted  = acc_next >>> SHIFT;
`ifdef NEURON_ACC_RELU_EN
        clamped  = (shifted < 0) ? '0 : shifted;
`else
        clamped  = shifted;
`endif
    end

    always_comb begin
        sat_data = clamped[15:0];
        sat_flag = 1'b0;
        if (clamped > SAT_MAX) begin
            sat_data = 16'sh7fff;
            sat_flag = 1'b1;
        end else if (clamped < SAT_MIN) begin
            sat_data = -16'sh8000;
            sat_flag = 1'b1;
        end
    end

    assign accept    = (state_q == ACCUM) && in_valid;
    assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    if (last_term) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = sat_data;
                        out_sat_d   = sat_flag;
                        state_d     = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q == DONE) || (cnt_q != '0);

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - randomized self-checking bench for neuron_accumulator (three configurations)
module tb_neuron_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] bias      [3];
    logic               in_valid  [3];
    logic               in_ready  [3];
    logic signed [16:0] in_sum    [3];
    logic               out_valid [3];
    logic               out_ready [3];
    logic signed [15:0] out_data  [3];
    logic               out_sat   [3];
    logic               busy      [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(.N_TERMS(4), .ACC_W(32), .SHIFT(0)) u_n4_s0 (
        .clk(clk), .rst(rst), .bias(bias[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_sum(in_sum[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_sat(out_sat[0]), .busy(busy[0]));

    neuron_accumulator #(.N_TERMS(4), .ACC_W(32), .SHIFT(2)) u_n4_s2 (
        .clk(clk), .rst(rst), .bias(bias[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_sum(in_sum[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_sat(out_sat[1]), .busy(busy[1]));

    neuron_accumulator #(.N_TERMS(1), .ACC_W(32), .SHIFT(0)) u_n1_s0 (
        .clk(clk), .rst(rst), .bias(bias[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_sum(in_sum[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .out_sat(out_sat[2]), .busy(busy[2]));

    function automatic int nt_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int sh_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_sum();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    // Reference: exact sum, floor division by 2^shift, optional ReLU, then clamp to int16.
    task automatic model(input int k, input int b, input int s[4], output longint ed, output bit es);
        logic signed [15:0] b16;
        longint a;
        b16 = b[15:0];
        a   = longint'(b16);
        for (int i = 0; i < nt_of(k); i++) a += s[i];
        a = a >>> sh_of(k);
`ifdef NEURON_ACC_RELU_EN
        if (a < 0) a = 0;
`endif
        es = 1'b1;
        if (a > 32767) ed = 32767;
        else if (a < -32768) ed = -32768;
        else begin
            ed = a;
            es = 1'b0;
        end
    endtask

    task automatic run_frame(input int k, input int b, input int s0, input int s1,
                             input int s2, input int s3, input bit gaps, input int hold);
        int     s[4];
        int     idx;
        int     cyc;
        bit     take;
        longint ed;
        bit     es;
        s   = '{s0, s1, s2, s3};
        idx = 0;
        cyc = 0;
        model(k, b, s, ed, es);
        bias[k] = b[15:0];
        while (idx < nt_of(k) && cyc < 200) begin
            chk("busy_in_frame", busy[k], (idx > 0) ? 1 : 0);
            chk("in_ready_accum", in_ready[k], 1);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid[k] = 1'b0;
                in_sum[k]   = 17'($urandom);
            end else begin
                in_valid[k] = 1'b1;
                in_sum[k]   = 17'(s[idx]);
            end
            take = in_valid[k] && in_ready[k];
            tick();
            cyc++;
            if (take) begin
                idx++;
                bias[k] = 16'($urandom);
            end
        end
        in_valid[k] = 1'b0;
        if (idx < nt_of(k)) chk("frame_accept_timeout", idx, nt_of(k));
        chk("out_valid_rise", out_valid[k], 1);
        chk("out_data", out_data[k], ed);
        chk("out_sat", out_sat[k], es);
        chk("busy_done", busy[k], 1);
        chk("in_ready_done", in_ready[k], 0);
        for (int h = 0; h < hold; h++) begin
            out_ready[k] = 1'b0;
            in_valid[k]  = 1'b1;
            in_sum[k]    = 17'($urandom);
            tick();
            chk("hold_valid", out_valid[k], 1);
            chk("hold_data", out_data[k], ed);
            chk("hold_sat", out_sat[k], es);
            chk("hold_in_ready", in_ready[k], 0);
            chk("hold_busy", busy[k], 1);
        end
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_sum[k]    = 17'($urandom);
        tick();
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        chk("handshake_valid", out_valid[k], 0);
        chk("no_bypass_busy", busy[k], 0);
        chk("handshake_in_ready", in_ready[k], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bias[i] = '0; in_valid[i] = 1'b0; in_sum[i] = '0; out_ready[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", out_valid[i], 0);
            chk("rst_out_data", out_data[i], 0);
            chk("rst_out_sat", out_sat[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_in_ready", in_ready[i], 1);
        end

        run_frame(0, 5, 100, 200, -50, 10, 1'b0, 0);
        run_frame(0, 32767, 65534, 65534, 65534, 65534, 1'b0, 0);
        run_frame(0, -32768, -65536, -65536, -65536, -65536, 1'b0, 0);
        run_frame(0, 7, 11, -22, 33, -44, 1'b0, 5);
        run_frame(0, 0, 1, 2, 3, 4, 1'b0, 0);

        bias[0] = 16'sd9;
        in_valid[0] = 1'b1;
        in_sum[0] = 17'sd1000;
        tick();
        tick();
        in_valid[0] = 1'b0;
        chk("mid_frame_busy", busy[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_out_sat", out_sat[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_in_ready", in_ready[0], 1);
        run_frame(0, 0, 1, 1, 1, 1, 1'b0, 0);

        run_frame(1, 0, 1001, 0, 0, 0, 1'b0, 0);
        run_frame(1, 0, -1001, 0, 0, 0, 1'b0, 0);
        run_frame(1, 0, 1001, 0, 0, 0, 1'b1, 1);
        run_frame(1, 0, -1001, 0, 0, 0, 1'b1, 2);
        run_frame(2, -100, 300, 0, 0, 0, 1'b0, 3);

        for (int f = 0; f < 60; f++) begin
            k = int'($urandom_range(0, 2));
            run_frame(k, int'($urandom_range(0, 65535)) - 32768, rnd_sum(), rnd_sum(),
                      rnd_sum(), rnd_sum(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
